// File: rtl/program_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory, then releases the CPU.
// Latency: each payload byte is written to memory one cycle after it is accepted; RUN/ERR follows the checksum byte by one cycle.
// Backpressure: in_ready is high only while a load is in progress (HDR/DATA/CSUM); no byte is taken otherwise.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset_n,
    output logic              load_done,
    output logic              load_err
);

    // One extra bit lets a full-capacity load count up to 2^ADDR_W without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam int CAP   = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   addr;
    logic [CNT_W-1:0]   addr_inc;
    logic [DATA_W-1:0]  csum;
    logic               accept;
    logic               hdr_ok;

    assign accept   = in_valid && in_ready;
    assign addr_inc = addr + 1'b1;
    // A header is usable only if it names between 1 and CAP bytes.
    assign hdr_ok   = (in_data != '0) && (32'(in_data) <= 32'(CAP));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only takes effect outside an active load.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = HDR;
            HDR:  if (accept) state_nxt = hdr_ok ? DATA : ERR;
            DATA: if (accept && (addr_inc == count)) state_nxt = CSUM;
            CSUM: if (accept) state_nxt = (in_data == csum) ? RUN : ERR;
            RUN:  if (start) state_nxt = HDR;
            ERR:  if (start) state_nxt = HDR;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        in_ready    = 1'b0;
        cpu_reset_n = 1'b0;
        load_done   = 1'b0;
        load_err    = 1'b0;
        case (state)
            HDR, DATA, CSUM: in_ready = 1'b1;
            RUN: begin
                cpu_reset_n = 1'b1;
                load_done   = 1'b1;
            end
            ERR:     load_err = 1'b1;
            default: ;
        endcase
    end

    // Datapath: byte counter, running checksum and the registered memory write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            addr      <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if ((state == HDR) && accept && hdr_ok) begin
                count <= CNT_W'(in_data);
                addr  <= '0;
                csum  <= '0;
            end
            if ((state == DATA) && accept) begin
                csum      <= csum ^ in_data;
                mem_we    <= 1'b1;
                mem_addr  <= addr[ADDR_W-1:0];
                mem_wdata <= in_data;
                addr      <= addr_inc;
            end
        end
    end

endmodule
